// File: rtl/csr_ip_map_pkg.sv
// -----------------------------------------------------------------------------
// csr_ip_map_pkg
// Purpose : Shared types and constants for the CSR_IP_Map register block.
//           - hwif structs (per-field .value / .next members) linking the CSR
//             block and the surrounding hardware.
//           - Register byte offsets and field position/width constants.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package csr_ip_map_pkg;

  // Register byte offsets (word aligned).
  localparam int CTRL_OFFSET   = 'h0;
  localparam int STATUS_OFFSET = 'h4;

  // CTRL field positions / widths.
  localparam int CTRL_PRESCALER_POS = 0;
  localparam int CTRL_PRESCALER_W   = 2;
  localparam int CTRL_MODE_POS      = 2;
  localparam int CTRL_MODE_W        = 2;
  localparam int CTRL_MASTER_POS    = 4;
  localparam int CTRL_DORD_POS      = 5;
  localparam int CTRL_ENABLE_POS    = 6;
  localparam int CTRL_CLK2X_POS     = 7;
  localparam int CTRL_W             = 8;

  // STATUS field positions.
  localparam int STATUS_SPIF_POS = 0;
  localparam int STATUS_WCOL_POS = 1;
  localparam int STATUS_BUSY_POS = 2;

  // ---- CTRL outputs -------------------------------------------------------
  typedef struct packed { logic [CTRL_PRESCALER_W-1:0] value; } CSR_IP_Map__ctrl__prescaler__out_t;
  typedef struct packed { logic [CTRL_MODE_W-1:0]      value; } CSR_IP_Map__ctrl__mode__out_t;
  typedef struct packed { logic value; } CSR_IP_Map__ctrl__master__out_t;
  typedef struct packed { logic value; } CSR_IP_Map__ctrl__dord__out_t;
  typedef struct packed { logic value; } CSR_IP_Map__ctrl__enable__out_t;
  typedef struct packed { logic value; } CSR_IP_Map__ctrl__clk2x__out_t;

  // Member order (MSB first) matches the CTRL bit layout, so the packed
  // struct is bit-for-bit the register word [7:0].
  typedef struct packed {
    CSR_IP_Map__ctrl__clk2x__out_t     clk2x;
    CSR_IP_Map__ctrl__enable__out_t    enable;
    CSR_IP_Map__ctrl__dord__out_t      dord;
    CSR_IP_Map__ctrl__master__out_t    master;
    CSR_IP_Map__ctrl__mode__out_t      mode;
    CSR_IP_Map__ctrl__prescaler__out_t prescaler;
  } CSR_IP_Map__ctrl__out_t;

  // ---- STATUS outputs -----------------------------------------------------
  typedef struct packed { logic value; } CSR_IP_Map__status__spif__out_t;

  typedef struct packed {
    CSR_IP_Map__status__spif__out_t spif;
  } CSR_IP_Map__status__out_t;

  typedef struct packed {
    CSR_IP_Map__ctrl__out_t   ctrl;
    CSR_IP_Map__status__out_t status;
  } CSR_IP_Map__out_t;

  // ---- STATUS inputs ------------------------------------------------------
  typedef struct packed { logic next; } CSR_IP_Map__status__wcol__in_t;
  typedef struct packed { logic next; } CSR_IP_Map__status__busy__in_t;

  typedef struct packed {
    CSR_IP_Map__status__busy__in_t busy;
    CSR_IP_Map__status__wcol__in_t wcol;
    logic                          spif_set;  // one-cycle set strobe for spif
  } CSR_IP_Map__status__in_t;

  typedef struct packed {
    CSR_IP_Map__status__in_t status;
  } CSR_IP_Map__in_t;

endpackage

// File: rtl/bus2master_intf.sv
// -----------------------------------------------------------------------------
// Bus2Master_intf
// Purpose : APB4 signal bundle between a bus master and a CSR slave.
// Modports: slave  - psel, penable, pwrite, paddr, pwdata in;
//                    prdata, pready, pslverr out.
//           master - the mirror image.
// -----------------------------------------------------------------------------
interface Bus2Master_intf #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/csr_ip_map.sv
// -----------------------------------------------------------------------------
// csr_ip_map
// Purpose : Register storage and address decode for CTRL (0x0) and
//           STATUS (0x4) behind a single-cycle req/wr cpuif.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           i_req           - access strobe (one cycle per transfer)
//           i_wr            - 1 = write, 0 = read
//           i_addr          - byte address
//           i_wdata         - write data
//           o_rdata         - read data (0 unless a mapped read is in progress)
//           o_err           - access targets an unmapped address
//           hwif_in/out     - hardware-side field interface
// -----------------------------------------------------------------------------
module csr_ip_map
  import csr_ip_map_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic                      i_wr,
  input  logic [CSR_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      o_err,
  input  CSR_IP_Map__in_t           hwif_in,
  output CSR_IP_Map__out_t          hwif_out
);

  CSR_IP_Map__ctrl__out_t r_ctrl;
  logic                   r_spif;

  logic                  w_hit_ctrl;
  logic                  w_hit_status;
  logic                  w_write_ctrl;
  logic                  w_clear_spif;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_wdata;

  // Full-address compare: byte lanes [1:0] must also match, so any
  // misaligned offset falls through to unmapped.
  assign w_hit_ctrl   = (i_addr == CSR_ADDR_WIDTH'(CTRL_OFFSET));
  assign w_hit_status = (i_addr == CSR_ADDR_WIDTH'(STATUS_OFFSET));

  assign w_write_ctrl = i_req & i_wr & w_hit_ctrl;
  assign w_clear_spif = i_req & i_wr & w_hit_status & i_wdata[STATUS_SPIF_POS];

  assign o_err = i_req & ~(w_hit_ctrl | w_hit_status);

  // Reserved write bits are intentionally dropped.
  assign w_unused_wdata = &{1'b0, i_wdata[DATA_WIDTH-1:CTRL_W]};

  // Reset has priority over any access, so a transfer whose commit edge
  // coincides with rst never reaches the registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) for every flop so all registers update from
    // the same pre-edge values, independent of statement order.
    if (rst) begin
      r_ctrl <= '0;
      r_spif <= 1'b0;
    end else begin
      if (w_write_ctrl) begin
        r_ctrl <= CSR_IP_Map__ctrl__out_t'(i_wdata[CTRL_W-1:0]);
      end
      // Hardware set outranks a software W1C in the same cycle.
      if (hwif_in.status.spif_set) begin
        r_spif <= 1'b1;
      end else if (w_clear_spif) begin
        r_spif <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_rdata and no latch is inferred.
    w_rdata = '0;
    if (i_req && !i_wr) begin
      if (w_hit_ctrl) begin
        w_rdata[CTRL_W-1:0] = r_ctrl;
      end else if (w_hit_status) begin
        w_rdata[STATUS_SPIF_POS] = r_spif;
        w_rdata[STATUS_WCOL_POS] = hwif_in.status.wcol.next;
        w_rdata[STATUS_BUSY_POS] = hwif_in.status.busy.next;
      end
    end
  end

  assign o_rdata = w_rdata;

  assign hwif_out.ctrl              = r_ctrl;
  assign hwif_out.status.spif.value = r_spif;

endmodule

// File: rtl/apb4_csr_top.sv
// -----------------------------------------------------------------------------
// apb4_csr_top
// Purpose : Zero-wait-state APB4 slave bridge in front of csr_ip_map.
// Ports   : clk               - single clock
//           rst               - synchronous active-high reset
//           apb42Master_intf  - APB4 slave modport
//           hwif_in           - hardware-to-CSR inputs
//           hwif_out          - CSR field values to hardware
// Config  : APB4_CSR_PSLVERR_EN - when defined, pslverr flags unmapped
//           accesses in the access phase; otherwise pslverr is tied 0.
//           Unmapped writes never take effect and unmapped reads return 0
//           in either build.
// -----------------------------------------------------------------------------
module apb4_csr_top
  import csr_ip_map_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 3,
  parameter int CSR_ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  Bus2Master_intf.slave    apb42Master_intf,
  input  CSR_IP_Map__in_t  hwif_in,
  output CSR_IP_Map__out_t hwif_out
);

  logic                      w_access;
  logic                      w_addr_hi_nz;
  logic                      w_req;
  logic [CSR_ADDR_WIDTH-1:0] w_csr_addr;
  logic [DATA_WIDTH-1:0]     w_rdata;
  logic                      w_err;

  // Only the access phase talks to the register block; setup is side-effect free.
  assign w_access = apb42Master_intf.psel & apb42Master_intf.penable;

  assign w_csr_addr = CSR_ADDR_WIDTH'(apb42Master_intf.paddr);

  // APB address bits above the CSR window make the access unmapped.
  generate
    if (ADDR_WIDTH > CSR_ADDR_WIDTH) begin : g_addr_hi
      assign w_addr_hi_nz = |apb42Master_intf.paddr[ADDR_WIDTH-1:CSR_ADDR_WIDTH];
    end else begin : g_addr_fit
      assign w_addr_hi_nz = 1'b0;
    end
  endgenerate

  assign w_req = w_access & ~w_addr_hi_nz;

  csr_ip_map #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CSR_ADDR_WIDTH(CSR_ADDR_WIDTH)
  ) u_csr_ip_map (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_req),
    .i_wr    (apb42Master_intf.pwrite),
    .i_addr  (w_csr_addr),
    .i_wdata (apb42Master_intf.pwdata),
    .o_rdata (w_rdata),
    .o_err   (w_err),
    .hwif_in (hwif_in),
    .hwif_out(hwif_out)
  );

  // Zero wait states: every access phase completes immediately.
  assign apb42Master_intf.pready = w_access;
  // csr_ip_map already returns 0 outside a mapped read.
  assign apb42Master_intf.prdata = w_rdata;

`ifdef APB4_CSR_PSLVERR_EN
  assign apb42Master_intf.pslverr = w_access & (w_err | w_addr_hi_nz);
`else
  logic w_unused_err;
  assign w_unused_err             = w_err;
  assign apb42Master_intf.pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_csr_top.sv
// -----------------------------------------------------------------------------
// tb_apb4_csr_top
// Purpose : Directed self-checking bench for apb4_csr_top. Expected pslverr
//           follows APB4_CSR_PSLVERR_EN as compiled.
// -----------------------------------------------------------------------------
module tb_apb4_csr_top;
  import csr_ip_map_pkg::*;

`ifdef APB4_CSR_PSLVERR_EN
  localparam logic [31:0] EXP_ERR = 32'h1;
`else
  localparam logic [31:0] EXP_ERR = 32'h0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  CSR_IP_Map__in_t  hwif_in;
  CSR_IP_Map__out_t hwif_out;

  Bus2Master_intf #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) apb ();

  apb4_csr_top #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (3),
    .CSR_ADDR_WIDTH(3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .apb42Master_intf(apb),
    .hwif_in         (hwif_in),
    .hwif_out        (hwif_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] g_rdata;
  logic [31:0] g_rdy;
  logic [31:0] g_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One APB transfer starting just after a rising edge: setup cycle, access
  // cycle, returns just after the commit edge. Outputs are sampled mid access
  // phase. set_pulse drives spif_set during the access cycle; rst_pulse
  // asserts rst for the access cycle's closing edge.
  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                          input logic set_pulse, input logic rst_pulse);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    @(posedge clk);
    #1;
    apb.penable = 1'b1;
    hwif_in.status.spif_set = set_pulse;
    if (rst_pulse) rst = 1'b1;
    #2;
    g_rdata = apb.prdata;
    g_rdy   = 32'(apb.pready);
    g_err   = 32'(apb.pslverr);
    @(posedge clk);
    #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    hwif_in.status.spif_set = 1'b0;
    if (rst_pulse) rst = 1'b0;
  endtask

  task automatic apb_wr(input logic [2:0] addr, input logic [31:0] wdata);
    apb_xfer(1'b1, addr, wdata, 1'b0, 1'b0);
  endtask

  task automatic apb_rd(input logic [2:0] addr);
    apb_xfer(1'b0, addr, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    hwif_in     = '0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    @(posedge clk);
    #1;

    // Reset: two edges with rst high while a write is attempted.
    apb_wr(3'h0, 32'h000000AA);
    check("rst_pready", g_rdy, 32'h1);
    rst = 1'b0;
    check("rst_hwif_ctrl", 32'(hwif_out.ctrl), 32'h0);
    check("rst_hwif_spif", 32'(hwif_out.status.spif.value), 32'h0);
    apb_rd(3'h0);
    check("rst_ctrl_rd", g_rdata, 32'h0);
    apb_rd(3'h4);
    check("rst_status_rd", g_rdata, 32'h0);

    // Setup phase alone must neither assert pready nor write.
    apb.psel   = 1'b1;
    apb.pwrite = 1'b1;
    apb.paddr  = 3'h0;
    apb.pwdata = 32'hFF;
    #1;
    check("setup_pready", 32'(apb.pready), 32'h0);
    @(posedge clk);
    #1;
    apb.psel = 1'b0;
    check("setup_no_write", 32'(hwif_out.ctrl), 32'h0);

    // Write 0xEF to CTRL.
    apb_wr(3'h0, 32'h000000EF);
    check("wr_ef_pready", g_rdy, 32'h1);
    check("wr_prdata_zero", g_rdata, 32'h0);
    check("hw_clk2x", 32'(hwif_out.ctrl.clk2x.value), 32'h1);
    check("hw_enable", 32'(hwif_out.ctrl.enable.value), 32'h1);
    check("hw_dord", 32'(hwif_out.ctrl.dord.value), 32'h1);
    check("hw_master", 32'(hwif_out.ctrl.master.value), 32'h0);
    check("hw_mode", 32'(hwif_out.ctrl.mode.value), 32'h3);
    check("hw_prescaler", 32'(hwif_out.ctrl.prescaler.value), 32'h3);
    check("hw_ctrl_packed", 32'(hwif_out.ctrl), 32'hEF);
    apb_rd(3'h0);
    check("rd_ef", g_rdata, 32'h000000EF);
    check("rd_ef_err", g_err, 32'h0);

    // Reserved bits discarded.
    apb_wr(3'h0, 32'hFFFFFFFF);
    apb_rd(3'h0);
    check("rd_ff", g_rdata, 32'h000000FF);

    // Unmapped accesses.
    apb_wr(3'h2, 32'h00000055);
    check("unmap_wr_err", g_err, EXP_ERR);
    apb_wr(3'h1, 32'h00000000);
    apb_rd(3'h0);
    check("unmap_ctrl_kept", g_rdata, 32'h000000FF);
    apb_rd(3'h6);
    check("unmap_rd6_data", g_rdata, 32'h0);
    check("unmap_rd6_err", g_err, EXP_ERR);
    hwif_in.status.wcol.next = 1'b1;
    apb_rd(3'h5);
    check("unmap_rd5_data", g_rdata, 32'h0);
    hwif_in.status.wcol.next = 1'b0;

    // spif set pulse, sticky across reads, W1C.
    hwif_in.status.spif_set = 1'b1;
    @(posedge clk);
    #1;
    hwif_in.status.spif_set = 1'b0;
    check("spif_hwif", 32'(hwif_out.status.spif.value), 32'h1);
    apb_rd(3'h4);
    check("spif_rd1", g_rdata, 32'h1);
    apb_rd(3'h4);
    check("spif_rd_sticky", g_rdata, 32'h1);
    hwif_in.status.wcol.next = 1'b1;
    hwif_in.status.busy.next = 1'b1;
    apb_rd(3'h4);
    check("status_live7", g_rdata, 32'h7);
    hwif_in.status.wcol.next = 1'b0;
    apb_rd(3'h4);
    check("status_live5", g_rdata, 32'h5);
    hwif_in.status.busy.next = 1'b0;
    apb_wr(3'h4, 32'h0);
    apb_rd(3'h4);
    check("w0_keeps_spif", g_rdata, 32'h1);
    apb_wr(3'h4, 32'h1);
    check("w1c_hwif", 32'(hwif_out.status.spif.value), 32'h0);
    apb_rd(3'h4);
    check("w1c_rd", g_rdata, 32'h0);
    apb_xfer(1'b1, 3'h4, 32'h1, 1'b1, 1'b0);
    apb_rd(3'h4);
    check("set_wins", g_rdata, 32'h1);

    // Back-to-back write then read, no idle cycle.
    apb_wr(3'h0, 32'h00000012);
    check("b2b_wr_pready", g_rdy, 32'h1);
    apb_rd(3'h0);
    check("b2b_rd_pready", g_rdy, 32'h1);
    check("b2b_rd_data", g_rdata, 32'h00000012);

    // Reset hits during a write's access phase: write dropped, state cleared.
    apb_xfer(1'b1, 3'h0, 32'h00000034, 1'b0, 1'b1);
    check("rst_flight_pready", g_rdy, 32'h1);
    check("rst_flight_ctrl", 32'(hwif_out.ctrl), 32'h0);
    check("rst_flight_spif", 32'(hwif_out.status.spif.value), 32'h0);
    apb_rd(3'h0);
    check("rst_flight_rd", g_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
